// File: rtl/memcore_bram_arbiter_pkg.sv
// Shared constants, the index-width helper and the response tag type used by the BRAM arbiter.
package memcore_arb_pkg;

    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 6;
    localparam int unsigned MaxReqIdxW   = 4;

    // Width needed to index n items, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [MaxReqIdxW-1:0] req_idx;
        logic                  port;
    } tag_t;

endpackage

// File: rtl/memcore_bram_arbiter_if.sv
// Requester-side and BRAM-side signal bundle of the arbiter; slave is the arbiter's view.
interface memcore_bram_arbiter_if #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 6
);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ-1:0]               req_we;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data;
    logic [ADDRESS_WIDTH-1:0]         mem_address0;
    logic                             mem_ce0;
    logic                             mem_we0;
    logic [DATA_WIDTH-1:0]            mem_d0;
    logic [DATA_WIDTH-1:0]            mem_q0;
    logic [ADDRESS_WIDTH-1:0]         mem_address1;
    logic                             mem_ce1;
    logic                             mem_we1;
    logic [DATA_WIDTH-1:0]            mem_d1;
    logic [DATA_WIDTH-1:0]            mem_q1;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_q0, mem_q1,
        output req_ready, rsp_valid, rsp_data,
        output mem_address0, mem_ce0, mem_we0, mem_d0,
        output mem_address1, mem_ce1, mem_we1, mem_d1
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_q0, mem_q1,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_address0, mem_ce0, mem_we0, mem_d0,
        input  mem_address1, mem_ce1, mem_we1, mem_d1
    );
endinterface

// File: rtl/memcore_bram_arbiter_rr_pick2.sv
// Round-robin picker: first two valid requesters from rr_ptr, second dropped on a write collision.
module rr_pick2
    import memcore_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DefNumReq,
    parameter int unsigned ADDRESS_WIDTH = DefAddrWidth
) (
    input  logic [NUM_REQ-1:0]               valid,
    input  logic [clog2(NUM_REQ)-1:0]        rr_ptr,
    input  logic [NUM_REQ-1:0]               we,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] addr,
    output logic [clog2(NUM_REQ)-1:0]        a_idx,
    output logic                             a_vld,
    output logic [clog2(NUM_REQ)-1:0]        b_idx,
    output logic                             b_vld,
    output logic [NUM_REQ-1:0]               ready
);
    localparam int unsigned REQ_IDX_W = clog2(NUM_REQ);

    logic                 cand_vld;
    logic [REQ_IDX_W-1:0] cand;
    logic                 conflict;

    always_comb begin
        a_vld    = 1'b0;
        a_idx    = '0;
        cand_vld = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned j;
            j = 32'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (valid[REQ_IDX_W'(j)]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = REQ_IDX_W'(j);
                end else if (!cand_vld) begin
                    cand_vld = 1'b1;
                    cand     = REQ_IDX_W'(j);
                end
            end
        end
        // No substitute search: a blocked second candidate simply waits.
        conflict = (addr[a_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH] ==
                    addr[cand*ADDRESS_WIDTH +: ADDRESS_WIDTH]) && (we[a_idx] || we[cand]);
        b_vld = cand_vld && !conflict;
        b_idx = cand;
        ready = '0;
        if (a_vld) ready[a_idx] = 1'b1;
        if (b_vld) ready[b_idx] = 1'b1;
    end

endmodule

// File: rtl/memcore_bram_arbiter.sv
// Shares a dual-port BRAM among NUM_REQ requesters: two round-robin grants per cycle,
// registered port drive, read data returned two cycles after acceptance.
module memcore_bram_arbiter
    import memcore_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DefNumReq,
    parameter int unsigned DATA_WIDTH    = DefDataWidth,
    parameter int unsigned ADDRESS_WIDTH = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  reset_n,
    memcore_bram_arbiter_if.slave bus
);
    localparam int unsigned REQ_IDX_W = clog2(NUM_REQ);

    logic [REQ_IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [REQ_IDX_W-1:0]     a_idx, b_idx;
    logic                     a_vld, b_vld;
    logic [NUM_REQ-1:0]       pick_ready;
    logic                     a_we, b_we;
    logic [ADDRESS_WIDTH-1:0] a_addr, b_addr;
    logic [DATA_WIDTH-1:0]    a_wdata, b_wdata;

    logic                     ce0_q, we0_q, ce1_q, we1_q;
    logic [ADDRESS_WIDTH-1:0] addr0_q, addr1_q;
    logic [DATA_WIDTH-1:0]    d0_q, d1_q;
    tag_t                     s1_tag_q [2];
    tag_t                     s2_tag_q [2];

    rr_pick2 #(
        .NUM_REQ      (NUM_REQ),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_pick (
        .valid (bus.req_valid),
        .rr_ptr(rr_ptr_q),
        .we    (bus.req_we),
        .addr  (bus.req_addr),
        .a_idx (a_idx),
        .a_vld (a_vld),
        .b_idx (b_idx),
        .b_vld (b_vld),
        .ready (pick_ready)
    );

    assign bus.req_ready = pick_ready & {NUM_REQ{reset_n}};

    assign a_we    = bus.req_we[a_idx];
    assign b_we    = bus.req_we[b_idx];
    assign a_addr  = bus.req_addr[a_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign b_addr  = bus.req_addr[b_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign a_wdata = bus.req_wdata[a_idx*DATA_WIDTH +: DATA_WIDTH];
    assign b_wdata = bus.req_wdata[b_idx*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (b_vld) begin
            rr_ptr_d = (b_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : b_idx + 1'b1;
        end else if (a_vld) begin
            rr_ptr_d = (a_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : a_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            ce0_q    <= 1'b0;
            we0_q    <= 1'b0;
            addr0_q  <= '0;
            d0_q     <= '0;
            ce1_q    <= 1'b0;
            we1_q    <= 1'b0;
            addr1_q  <= '0;
            d1_q     <= '0;
            for (int p = 0; p < 2; p++) begin
                s1_tag_q[p] <= '0;
                s2_tag_q[p] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            ce0_q    <= a_vld;
            we0_q    <= a_vld && a_we;
            ce1_q    <= b_vld;
            we1_q    <= b_vld && b_we;
            if (a_vld) begin
                addr0_q <= a_addr;
                d0_q    <= a_wdata;
            end
            if (b_vld) begin
                addr1_q <= b_addr;
                d1_q    <= b_wdata;
            end
            s1_tag_q[0] <= '{valid: a_vld && !a_we, req_idx: MaxReqIdxW'(a_idx), port: 1'b0};
            s1_tag_q[1] <= '{valid: b_vld && !b_we, req_idx: MaxReqIdxW'(b_idx), port: 1'b1};
            s2_tag_q    <= s1_tag_q;
        end
    end

    assign bus.mem_ce0      = ce0_q;
    assign bus.mem_we0      = we0_q;
    assign bus.mem_address0 = addr0_q;
    assign bus.mem_d0       = d0_q;
    assign bus.mem_ce1      = ce1_q;
    assign bus.mem_we1      = we1_q;
    assign bus.mem_address1 = addr1_q;
    assign bus.mem_d1       = d1_q;

    // Read data flows straight from the BRAM output, steered by the stage-2 tag.
    always_comb begin
        logic [REQ_IDX_W-1:0] ridx;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        for (int p = 0; p < 2; p++) begin
            ridx = s2_tag_q[p].req_idx[REQ_IDX_W-1:0];
            if (s2_tag_q[p].valid) begin
                bus.rsp_valid[ridx] = 1'b1;
                bus.rsp_data[ridx*DATA_WIDTH +: DATA_WIDTH] =
                    s2_tag_q[p].port ? bus.mem_q1 : bus.mem_q0;
            end
        end
    end

endmodule

// File: tb/tb_memcore_bram_arbiter.sv
// Bench for memcore_bram_arbiter: directed scenarios then random traffic against a
// transaction-level model of grants, port drive and read responses.
module tb_memcore_bram_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    memcore_bram_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    memcore_bram_arbiter #(
        .NUM_REQ      (NR),
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Simple true-dual-port BRAM with one-cycle registered read.
    logic [DW-1:0] ram [0:63] = '{default: '0};
    logic [DW-1:0] q0_r = '0;
    logic [DW-1:0] q1_r = '0;
    always @(posedge clk) begin
        if (bus.mem_ce0) begin
            if (bus.mem_we0) ram[bus.mem_address0] <= bus.mem_d0;
            else q0_r <= ram[bus.mem_address0];
        end
        if (bus.mem_ce1) begin
            if (bus.mem_we1) ram[bus.mem_address1] <= bus.mem_d1;
            else q1_r <= ram[bus.mem_address1];
        end
    end
    assign bus.mem_q0 = q0_r;
    assign bus.mem_q1 = q1_r;

    // Requester stimulus
    logic [NR-1:0] pv, pwe;
    logic [AW-1:0] pa [NR];
    logic [DW-1:0] pd [NR];
    int mode;
    assign bus.req_valid = pv;
    assign bus.req_we    = pwe;
    for (genvar g = 0; g < NR; g++) begin : g_drv
        assign bus.req_addr[g*AW +: AW]  = pa[g];
        assign bus.req_wdata[g*DW +: DW] = pd[g];
    end

    // Reference model state
    int            mptr;
    logic [1:0]    ece, ewe;
    logic [AW-1:0] ea [2];
    logic [DW-1:0] ed [2];
    logic [NR-1:0] erv1, erv2;
    logic [NR*DW-1:0] erd1, erd2;
    logic [DW-1:0] shadow [0:63] = '{default: '0};

    logic [NR-1:0]    obs_rdy, obs_rv;
    logic [NR*DW-1:0] obs_rd;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        mptr = 0;
        ece  = '0;
        ewe  = '0;
        erv1 = '0;
        erv2 = '0;
        erd1 = '0;
        erd2 = '0;
    endtask

    task automatic renew(input int i);
        case (mode)
            1: begin
                pv[i]  = ($urandom_range(0, 3) != 0);
                pwe[i] = ($urandom_range(0, 2) == 0);
                pa[i]  = AW'($urandom_range(0, 7));
                pd[i]  = $urandom;
            end
            2: pv[i] = 1'b1;
            default: pv[i] = 1'b0;
        endcase
    endtask

    task automatic accept(input int p, input int i);
        ece[p] = 1'b1;
        ewe[p] = pwe[i];
        ea[p]  = pa[i];
        ed[p]  = pd[i];
        if (!pwe[i]) begin
            erv1[i] = 1'b1;
            erd1[i*DW +: DW] = shadow[pa[i]];
        end
    endtask

    // One clock cycle: compare everything at the falling edge, advance the model, then
    // update requesters just after the rising edge.
    task automatic step();
        int order[$];
        int ga, gb;
        bit av, bv;
        logic [NR-1:0] rdy;
        @(negedge clk);
        for (int k = 0; k < NR; k++) begin
            if (pv[(mptr + k) % NR]) order.push_back((mptr + k) % NR);
        end
        av = (order.size() > 0);
        bv = 1'b0;
        ga = 0;
        gb = 0;
        if (av) ga = order[0];
        if (order.size() > 1) begin
            gb = order[1];
            bv = !((pa[gb] == pa[ga]) && (pwe[ga] || pwe[gb]));
        end
        rdy = '0;
        if (av) rdy[ga] = 1'b1;
        if (bv) rdy[gb] = 1'b1;
        obs_rdy = bus.req_ready;
        obs_rv  = bus.rsp_valid;
        obs_rd  = bus.rsp_data;
        chk("ready", obs_rdy, rdy);
        chk("ce0", bus.mem_ce0, ece[0]);
        chk("ce1", bus.mem_ce1, ece[1]);
        if (ece[0]) begin
            chk("we0", bus.mem_we0, ewe[0]);
            chk("addr0", bus.mem_address0, ea[0]);
            if (ewe[0]) chk("d0", bus.mem_d0, ed[0]);
        end
        if (ece[1]) begin
            chk("we1", bus.mem_we1, ewe[1]);
            chk("addr1", bus.mem_address1, ea[1]);
            if (ewe[1]) chk("d1", bus.mem_d1, ed[1]);
        end
        chk("rsp_valid", obs_rv, erv2);
        chk("rsp_data", obs_rd, erd2);
        chk("port_collision", bus.mem_ce0 && bus.mem_ce1 &&
            (bus.mem_address0 == bus.mem_address1) && (bus.mem_we0 || bus.mem_we1), 1'b0);
        erv2 = erv1;
        erd2 = erd1;
        erv1 = '0;
        erd1 = '0;
        ece  = '0;
        ewe  = '0;
        if (av) accept(0, ga);
        if (bv) accept(1, gb);
        if (av && pwe[ga]) shadow[pa[ga]] = pd[ga];
        if (bv && pwe[gb]) shadow[pa[gb]] = pd[gb];
        if (bv) mptr = (gb + 1) % NR;
        else if (av) mptr = (ga + 1) % NR;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (rdy[i] || (mode == 1 && !pv[i])) renew(i);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, bus.req_ready, '0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, '0);
        chk({tag, "_ce"}, {bus.mem_ce1, bus.mem_ce0}, 2'b00);
        chk({tag, "_we"}, {bus.mem_we1, bus.mem_we0}, 2'b00);
        chk({tag, "_addr"}, {bus.mem_address1, bus.mem_address0}, '0);
        chk({tag, "_d"}, {bus.mem_d1, bus.mem_d0}, '0);
    endtask

    initial begin
        mode = 0;
        for (int i = 0; i < NR; i++) begin
            pa[i] = AW'(16 + i);
            pd[i] = '0;
        end
        pwe = '0;
        pv  = '1;
        clear_model();

        // Reset held with everybody requesting
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Continuous reads to distinct addresses: pairs (0,1),(2,3),...
        mode = 2;
        step();
        chk("t1_first_pair", obs_rdy, 4'b0011);
        step();
        chk("t1_second_pair", obs_rdy, 4'b1100);
        repeat (8) step();

        // Drain, then write followed by read of the same word
        mode = 0;
        pv = '0;
        repeat (3) step();
        pv[2] = 1'b1; pwe[2] = 1'b1; pa[2] = 6'd5; pd[2] = 32'hDEADBEEF;
        step();
        pv[2] = 1'b1; pwe[2] = 1'b0; pa[2] = 6'd5;
        step();
        step();
        step();
        chk("t2_rsp_valid", obs_rv, 4'b0100);
        chk("t2_rsp_data", obs_rd[2*DW +: DW], 32'hDEADBEEF);

        // Same-address writes cannot pair
        pv[0] = 1'b1; pwe[0] = 1'b1; pa[0] = 6'd9; pd[0] = 32'h1111_0000;
        pv[1] = 1'b1; pwe[1] = 1'b1; pa[1] = 6'd9; pd[1] = 32'h2222_0000;
        step();
        chk("t3_only_req0", obs_rdy, 4'b0001);
        step();
        chk("t3_req1_next", obs_rdy, 4'b0010);
        repeat (2) step();

        // Same-address reads do pair
        pv[0] = 1'b1; pwe[0] = 1'b1; pa[0] = 6'd7; pd[0] = 32'h0000_1234;
        step();
        pv[1] = 1'b1; pwe[1] = 1'b0; pa[1] = 6'd7;
        pv[3] = 1'b1; pwe[3] = 1'b0; pa[3] = 6'd7;
        step();
        chk("t5_both_granted", obs_rdy, 4'b1010);
        step();
        step();
        chk("t5_rsp_valid", obs_rv, 4'b1010);
        chk("t5_rsp1", obs_rd[1*DW +: DW], 32'h0000_1234);
        chk("t5_rsp3", obs_rd[3*DW +: DW], 32'h0000_1234);

        // Reset pulse one cycle after a read is accepted
        pv[0] = 1'b1; pwe[0] = 1'b0; pa[0] = 6'd7;
        step();
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("t6_async");
        @(posedge clk);
        #2 reset_n = 1'b1;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b1; pwe[i] = 1'b0; pa[i] = AW'(20 + i);
        end
        step();
        chk("t6_no_rsp", obs_rv, 4'b0000);
        chk("t6_ptr_from_0", obs_rdy, 4'b0011);
        repeat (3) step();

        // Random traffic with frequent address collisions
        mode = 1;
        for (int i = 0; i < NR; i++) renew(i);
        repeat (400) step();
        mode = 0;
        pv = '0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
